// File: rtl/mac_rx_pkg.sv
// Shared types and helpers for the MAC RX read controller.
//   rx_state_e    : controller FSM states (IDLE, REQ, XFER, DESC)
//   ERR_OVERSIZE  : desc_err bit for an oversize/truncated frame
//   ERR_TIMEOUT   : desc_err bit for an idle-dv watchdog abort
//   ben_to_bytes  : EOP byte-enable code -> number of valid bytes (1..4)
package mac_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DESC = 2'd3
  } rx_state_e;

  localparam int unsigned ERR_OVERSIZE = 0;
  localparam int unsigned ERR_TIMEOUT  = 1;

  // 00 encodes a full word; other codes are the byte count directly.
  function automatic logic [2:0] ben_to_bytes(input logic [1:0] ben);
    return (ben == 2'b00) ? 3'd4 : {1'b0, ben};
  endfunction

endpackage

// File: rtl/mac_rx_desc_reg.sv
// Frame descriptor holding register with valid/ready handshake.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : capture base/len/err and raise desc_valid_o
//   base_i/len_i/err_i : descriptor fields to capture
//   desc_ready_i  : consumer accepts the descriptor
//   desc_valid_o, desc_base_o, desc_len_o, desc_err_o : held descriptor
//   desc_accept_o : handshake completes this cycle
//   frame_cnt_o   : number of descriptors accepted (wraps)
module mac_rx_desc_reg #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [15:0]       len_i,
  input  logic [1:0]        err_i,
  input  logic              desc_ready_i,
  output logic              desc_valid_o,
  output logic [ADDR_W-1:0] desc_base_o,
  output logic [15:0]       desc_len_o,
  output logic [1:0]        desc_err_o,
  output logic              desc_accept_o,
  output logic [31:0]       frame_cnt_o
);

  assign desc_accept_o = desc_valid_o & desc_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_valid_o <= 1'b0;
      desc_base_o  <= '0;
      desc_len_o   <= '0;
      desc_err_o   <= '0;
      frame_cnt_o  <= '0;
    end else begin
      if (load_i) begin
        desc_valid_o <= 1'b1;
        desc_base_o  <= base_i;
        desc_len_o   <= len_i;
        desc_err_o   <= err_i;
      end else if (desc_accept_o) begin
        // Fields stay as they were; only valid drops.
        desc_valid_o <= 1'b0;
        frame_cnt_o  <= frame_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: rtl/mac_rx_read_ctrl.sv
// MAC RX client read sequencer: requests frames from the tri-mode MAC,
// writes framed words into a circular word-addressed buffer and issues one
// descriptor (base, byte length, error flags) per frame.
// Optional feature: define MAC_RX_TIMEOUT_EN to enable the idle-dv watchdog
// in XFER (aborts the frame after TIMEOUT_CYC dv-less cycles, err[1]).
// Ports:
//   mac_clk_i, mac_rst_i        : clock, synchronous active-high reset
//   mac_rxd_i, mac_ben_i        : RX word and EOP valid-byte code
//   mac_rxda_i                  : MAC has a frame available
//   mac_rxsop_i/eop_i/dv_i      : framing and data-valid qualifiers
//   mac_rxrqrd_o                : read request to the MAC
//   buf_free_i                  : free words in the buffer
//   buf_wr_en_o/addr_o/data_o   : registered buffer write port
//   desc_valid_o/ready_i        : descriptor handshake
//   desc_base_o/len_o/err_o     : descriptor fields
//   frame_cnt_o                 : descriptors issued (wraps)
//   drop_cnt_o                  : discarded words (saturating)
module mac_rx_read_ctrl
  import mac_rx_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MAX_WORDS   = 380,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              mac_clk_i,
  input  logic              mac_rst_i,
  input  logic [31:0]       mac_rxd_i,
  input  logic [1:0]        mac_ben_i,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  input  logic [ADDR_W:0]   buf_free_i,
  output logic              buf_wr_en_o,
  output logic [ADDR_W-1:0] buf_wr_addr_o,
  output logic [31:0]       buf_wr_data_o,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_base_o,
  output logic [15:0]       desc_len_o,
  output logic [1:0]        desc_err_o,
  output logic [31:0]       frame_cnt_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  if (MAX_WORDS < 1 || MAX_WORDS > (1 << ADDR_W) || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("mac_rx_read_ctrl: invalid parameter combination");
  end

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, base_q, wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              wr_en_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic              in_frame_q, oversize_q;
  logic [1:0]        eop_ben_q;
  logic [15:0]       drop_q;
  logic              load_q;
  logic              desc_accept;

  logic accept_word, word_full, store_word, over_drop, pre_sop_drop, eop_seen;
  logic timeout_hit, timeout_flag;
  logic [15:0] len_calc, cnt16;
  logic [1:0]  err_calc;

  // A word belongs to the frame once SOP has been seen; a later SOP is data.
  assign accept_word  = (state_q == XFER) && mac_rxdv_i && (in_frame_q || mac_rxsop_i);
  assign pre_sop_drop = (state_q == XFER) && mac_rxdv_i && !in_frame_q && !mac_rxsop_i;
  assign word_full    = (word_cnt_q == WC_W'(MAX_WORDS));
  assign store_word   = accept_word && !word_full;
  assign over_drop    = accept_word && word_full;
  assign eop_seen     = accept_word && mac_rxeop_i;

`ifdef MAC_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_q;
  logic            timeout_q;

  assign timeout_hit  = (state_q == XFER) && !mac_rxdv_i &&
                        (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign timeout_flag = timeout_q;

  always_ff @(posedge mac_clk_i) begin
    if (mac_rst_i || state_q == REQ) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == XFER) begin
      if (mac_rxdv_i) idle_cnt_q <= '0;
      else            idle_cnt_q <= idle_cnt_q + TO_W'(1);
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // State register
  always_ff @(posedge mac_clk_i) begin
    if (mac_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mac_rxda_i && buf_free_i >= (ADDR_W+1)'(MAX_WORDS)) state_d = REQ;
      REQ:  state_d = XFER;
      XFER: if (eop_seen || timeout_hit) state_d = DESC;
      DESC: if (desc_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mac_rxrqrd_o = 1'b0;
    unique case (state_q)
      REQ, XFER: mac_rxrqrd_o = 1'b1;
      default:   mac_rxrqrd_o = 1'b0;
    endcase
  end

  // Datapath: write pipeline, frame accounting, drop counter
  always_ff @(posedge mac_clk_i) begin
    if (mac_rst_i) begin
      wr_ptr_q   <= '0;
      base_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      word_cnt_q <= '0;
      in_frame_q <= 1'b0;
      oversize_q <= 1'b0;
      eop_ben_q  <= '0;
      drop_q     <= '0;
      load_q     <= 1'b0;
    end else begin
      wr_en_q <= store_word;
      if (store_word) begin
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= mac_rxd_i;
        wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
      end
      // Descriptor is captured one cycle after entering DESC, i.e. in step
      // with the last buffer write becoming visible.
      load_q <= (state_q == XFER) && (state_d == DESC);

      if (state_q == REQ) begin
        base_q     <= wr_ptr_q;
        word_cnt_q <= '0;
        in_frame_q <= 1'b0;
        oversize_q <= 1'b0;
        eop_ben_q  <= '0;
      end else if (state_q == XFER) begin
        if (accept_word) in_frame_q <= 1'b1;
        if (store_word)  word_cnt_q <= word_cnt_q + WC_W'(1);
        if (over_drop)   oversize_q <= 1'b1;
        if (eop_seen)    eop_ben_q  <= mac_ben_i;
      end

      if ((pre_sop_drop || over_drop) && drop_q != '1) drop_q <= drop_q + 16'd1;
    end
  end

  always_comb begin
    cnt16 = 16'(word_cnt_q);
    if (timeout_flag)    len_calc = cnt16 << 2;
    else if (oversize_q) len_calc = 16'(MAX_WORDS * 4);
    else                 len_calc = ((cnt16 - 16'd1) << 2) + 16'(ben_to_bytes(eop_ben_q));
    err_calc               = '0;
    err_calc[ERR_OVERSIZE] = oversize_q;
    err_calc[ERR_TIMEOUT]  = timeout_flag;
  end

  mac_rx_desc_reg #(
    .ADDR_W (ADDR_W)
  ) u_desc_reg (
    .clk           (mac_clk_i),
    .rst           (mac_rst_i),
    .load_i        (load_q),
    .base_i        (base_q),
    .len_i         (len_calc),
    .err_i         (err_calc),
    .desc_ready_i  (desc_ready_i),
    .desc_valid_o  (desc_valid_o),
    .desc_base_o   (desc_base_o),
    .desc_len_o    (desc_len_o),
    .desc_err_o    (desc_err_o),
    .desc_accept_o (desc_accept),
    .frame_cnt_o   (frame_cnt_o)
  );

  assign buf_wr_en_o   = wr_en_q;
  assign buf_wr_addr_o = wr_addr_q;
  assign buf_wr_data_o = wr_data_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_mac_rx_read_ctrl.sv
module tb_mac_rx_read_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rxd = '0;
  logic [1:0]  ben = '0;
  logic        rxda = 1'b0, sop = 1'b0, eop = 1'b0, dv = 1'b0;
  logic        rqrd;
  logic [12:0] buf_free = 13'd4096;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        desc_valid;
  logic        desc_ready = 1'b1;
  logic [11:0] desc_base;
  logic [15:0] desc_len;
  logic [1:0]  desc_err;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [11:0] base; logic [15:0] len; logic [1:0] err; } desc_t;
  wr_t   wr_q[$];
  desc_t desc_q[$];

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  int exp_drop = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  mac_rx_read_ctrl dut (
    .mac_clk_i     (clk),
    .mac_rst_i     (rst),
    .mac_rxd_i     (rxd),
    .mac_ben_i     (ben),
    .mac_rxda_i    (rxda),
    .mac_rxsop_i   (sop),
    .mac_rxeop_i   (eop),
    .mac_rxdv_i    (dv),
    .mac_rxrqrd_o  (rqrd),
    .buf_free_i    (buf_free),
    .buf_wr_en_o   (wr_en),
    .buf_wr_addr_o (wr_addr),
    .buf_wr_data_o (wr_data),
    .desc_valid_o  (desc_valid),
    .desc_ready_i  (desc_ready),
    .desc_base_o   (desc_base),
    .desc_len_o    (desc_len),
    .desc_err_o    (desc_err),
    .frame_cnt_o   (frame_cnt),
    .drop_cnt_o    (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a descriptor handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", {20'd0, wr_addr}, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", {20'd0, wr_addr}, {20'd0, w.addr});
          check("wr_data", wr_data, w.data);
        end
      end
      if (desc_valid && desc_ready) begin
        if (desc_q.size() == 0) check("desc_unexpected", {20'd0, desc_base}, 32'hFFFF_FFFF);
        else begin
          desc_t d;
          d = desc_q.pop_front();
          check("desc_base", {20'd0, desc_base}, {20'd0, d.base});
          check("desc_len", {16'd0, desc_len}, {16'd0, d.len});
          check("desc_err", {30'd0, desc_err}, {30'd0, d.err});
        end
      end
    end
  end

  function automatic logic [31:0] word_of(input int fid, input int i);
    return {8'(fid), 24'(i)} ^ 32'h5A00_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise rxda, wait for the read request, then one more cycle so the DUT is in XFER.
  task automatic wait_start();
    int n;
    n = 0;
    rxda = 1'b1;
    while (!rqrd && n < 200) begin
      tick();
      n++;
    end
    check("rqrd_wait", {31'd0, rqrd}, 32'd1);
    tick();
  endtask

  task automatic drive_frame(input int n, input logic [1:0] b, input int pre,
                             input int dup_sop, input int with_eop, input int fid);
    for (int p = 0; p < pre; p++) begin
      dv = 1'b1; sop = 1'b0; eop = 1'b0; rxd = 32'hDEAD_0000 + 32'(p);
      exp_drop++;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      wr_t w;
      dv  = 1'b1;
      sop = (i == 0) || (dup_sop != 0 && i == 2);
      eop = (with_eop != 0) && (i == n - 1);
      ben = b;
      rxd = word_of(fid, i);
      if (i < 380) begin
        w.addr = 12'(exp_ptr);
        w.data = word_of(fid, i);
        wr_q.push_back(w);
        exp_ptr = (exp_ptr + 1) % 4096;
      end else exp_drop++;
      tick();
    end
    dv = 1'b0; sop = 1'b0; eop = 1'b0; ben = 2'b00;
    rxda = 1'b0;
  endtask

  task automatic push_desc(input int base, input int len, input logic [1:0] err);
    desc_t d;
    d.base = 12'(base);
    d.len  = 16'(len);
    d.err  = err;
    desc_q.push_back(d);
  endtask

  // Waits for the descriptor, lets the handshake complete and checks frame_cnt.
  task automatic finish_desc();
    int n;
    n = 0;
    while (!desc_valid && n < 50) begin
      tick();
      n++;
    end
    check("desc_appear", {31'd0, desc_valid}, 32'd1);
    tick();
    exp_frames++;
    check("frame_cnt", frame_cnt, 32'(exp_frames));
  endtask

  task automatic send(input int n, input logic [1:0] b, input int len, input logic [1:0] err,
                      input int pre, input int dup_sop, input int fid);
    push_desc(exp_ptr, len, err);
    wait_start();
    drive_frame(n, b, pre, dup_sop, 1, fid);
    finish_desc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    // Reset state
    check("rst_rqrd", {31'd0, rqrd}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_desc_valid", {31'd0, desc_valid}, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // 1: 4-word frame, ben=10 -> len 14, base 0
    send(4, 2'b10, 14, 2'b00, 0, 0, 1);

    // 2: single-word frame, descriptor held pending for 10 cycles
    desc_ready = 1'b0;
    push_desc(4, 1, 2'b00);
    wait_start();
    drive_frame(1, 2'b01, 0, 0, 1, 2);
    begin
      int n;
      n = 0;
      while (!desc_valid && n < 50) begin
        tick();
        n++;
      end
    end
    rxda = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("hold_valid", {31'd0, desc_valid}, 32'd1);
      check("hold_base", {20'd0, desc_base}, 32'd4);
      check("hold_len", {16'd0, desc_len}, 32'd1);
      check("hold_rqrd", {31'd0, rqrd}, 32'd0);
      tick();
    end
    rxda = 1'b0;
    desc_ready = 1'b1;
    tick();
    exp_frames++;
    check("frame_cnt", frame_cnt, 32'(exp_frames));

    // 3: insufficient buffer space blocks the request
    buf_free = 13'd100;
    rxda = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("lowfree_rqrd", {31'd0, rqrd}, 32'd0);
    end
    buf_free = 13'd400;
    tick();
    check("free_req_rqrd", {31'd0, rqrd}, 32'd1);
    tick();
    push_desc(5, 7, 2'b00);
    drive_frame(2, 2'b11, 0, 0, 1, 3);
    finish_desc();
    buf_free = 13'd4096;

    // 4: oversize 400-word frame
    send(400, 2'b00, 1520, 2'b01, 0, 0, 4);
    check("drop_oversize", {16'd0, drop_cnt}, 32'(exp_drop));

    // Fill up to pointer 4094; first filler has a pre-SOP word and a repeated SOP
    begin
      int fid;
      fid = 10;
      while (exp_ptr != 4094) begin
        int n;
        n = 4094 - exp_ptr;
        if (n > 380) n = 380;
        send(n, 2'b00, n * 4, 2'b00, (fid == 10) ? 1 : 0, (fid == 10) ? 1 : 0, fid);
        fid++;
      end
    end
    check("drop_presop", {16'd0, drop_cnt}, 32'(exp_drop));

    // 5: frame straddling the pointer wrap
    send(5, 2'b11, 19, 2'b00, 0, 0, 5);

`ifdef MAC_RX_TIMEOUT_EN
    // 6a: watchdog abort after 3 words
    begin
      int n;
      push_desc(exp_ptr, 12, 2'b10);
      wait_start();
      drive_frame(3, 2'b00, 0, 0, 0, 6);
      n = 0;
      while (rqrd && n < 1100) begin
        tick();
        n++;
      end
      check("timeout_cycles", 32'(n), 32'd1024);
      finish_desc();
    end
`endif

    // 6b: reset mid-frame abandons the frame
    wait_start();
    drive_frame(3, 2'b00, 0, 0, 0, 7);
    rxda = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_rqrd", {31'd0, rqrd}, 32'd0);
    check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midrst_wr_addr", {20'd0, wr_addr}, 32'd0);
    check("midrst_wr_data", wr_data, 32'd0);
    check("midrst_valid", {31'd0, desc_valid}, 32'd0);
    check("midrst_len", {16'd0, desc_len}, 32'd0);
    check("midrst_base", {20'd0, desc_base}, 32'd0);
    check("midrst_err", {30'd0, desc_err}, 32'd0);
    check("midrst_frame_cnt", frame_cnt, 32'd0);
    check("midrst_drop", {16'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    rxda = 1'b0;
    exp_ptr = 0;
    exp_drop = 0;
    exp_frames = 0;
    repeat (20) tick();
    check("postrst_no_desc", {31'd0, desc_valid}, 32'd0);

    // Pointer restarts at 0 after reset
    send(2, 2'b00, 8, 2'b00, 0, 0, 8);

    repeat (5) tick();
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check("desc_queue_empty", 32'(desc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
